// File: rtl/pong_engine.sv
// Two-player Pong engine: ball, two paddles, scoring, serve delay, game over.
// Ports: Clock, Reset (sync, active-low), Tick strobe, Serve, paddle buttons,
//        xPos/yPos pixel in; drawBall/drawPadL/drawPadR (1-clk latency),
//        scoreL/scoreR, gameOver, state (debug) out.

module pong_engine #(
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 600,
  parameter int BALL_SIZE   = 8,
  parameter int PAD_W       = 8,
  parameter int PAD_H       = 64,
  parameter int PAD_XL      = 16,
  parameter int PAD_XR      = 776,
  parameter int BALL_STEP   = 2,
  parameter int PAD_STEP    = 4,
  parameter int SERVE_TICKS = 60,
  parameter int WIN_SCORE   = 9,
  parameter int SCORE_W     = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Tick,
  input  logic               Serve,
  input  logic               LeftUp,
  input  logic               LeftDown,
  input  logic               RightUp,
  input  logic               RightDown,
  input  logic [11:0]        xPos,
  input  logic [11:0]        yPos,
  output logic               drawBall,
  output logic               drawPadL,
  output logic               drawPadR,
  output logic [SCORE_W-1:0] scoreL,
  output logic [SCORE_W-1:0] scoreR,
  output logic               gameOver,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    PLAY       = 3'd2,
    GAME_OVER  = 3'd3
  } state_t;

  localparam int CNT_W = $clog2(SERVE_TICKS + 1);

  localparam logic [11:0] BX0 =
    12'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [11:0] BY0 =
    12'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [11:0] PY0 =
    12'((V_ACTIVE - PAD_H) / 2);
  localparam logic [11:0] PY_MAX =
    12'(V_ACTIVE - PAD_H);
  localparam logic [11:0] BY_MAX =
    12'(V_ACTIVE - BALL_SIZE);
  localparam logic [11:0] H_MAX = 12'(H_ACTIVE);
  localparam logic [11:0] V_MAX = 12'(V_ACTIVE);
  localparam logic [11:0] BS    = 12'(BALL_SIZE);
  localparam logic [11:0] PW    = 12'(PAD_W);
  localparam logic [11:0] PH    = 12'(PAD_H);
  localparam logic [11:0] XL    = 12'(PAD_XL);
  localparam logic [11:0] XR    = 12'(PAD_XR);
  localparam logic [11:0] XL_IN = 12'(PAD_XL + PAD_W);
  localparam logic [11:0] XR_IN =
    12'(PAD_XR - BALL_SIZE);
  localparam logic [11:0] STEP  = 12'(BALL_STEP);
  localparam logic [11:0] PSTEP = 12'(PAD_STEP);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(SERVE_TICKS - 1);
  localparam logic [SCORE_W-1:0] WIN =
    SCORE_W'(WIN_SCORE);

  state_t state_q, state_d;

  logic [11:0] ball_x, ball_x_d;
  logic [11:0] ball_y, ball_y_d;
  logic [11:0] pad_l, pad_l_d;
  logic [11:0] pad_r, pad_r_d;
  // dir_x: 1 = right; dir_y: 1 = down
  logic dir_x, dir_x_d;
  logic dir_y, dir_y_d;
  logic [SCORE_W-1:0] score_l, score_l_d;
  logic [SCORE_W-1:0] score_r, score_r_d;
  logic [SCORE_W-1:0] inc_l, inc_r;
  logic [CNT_W-1:0] cnt, cnt_d;

  logic ovl_l, ovl_r;
  logic hit_l, hit_r;
  logic miss_l, miss_r;
  logic in_ball, in_pad_l, in_pad_r;

  function automatic logic [11:0] pad_next(
    input logic [11:0] y,
    input logic        up,
    input logic        dn
  );
    logic [11:0] r;
    r = y;
    if (up && !dn)
      r = (y < PSTEP) ? 12'd0 : y - PSTEP;
    else if (dn && !up)
      r = (y + PSTEP > PY_MAX) ? PY_MAX : y + PSTEP;
    return r;
  endfunction

  // Subtractions are rewritten as additions so nothing underflows.
  assign ovl_l = (ball_y + BS > pad_l) &&
                 (ball_y < pad_l + PH);
  assign ovl_r = (ball_y + BS > pad_r) &&
                 (ball_y < pad_r + PH);

  assign hit_l = !dir_x &&
                 (ball_x >= XL_IN) &&
                 (ball_x < XL_IN + STEP) && ovl_l;
  assign hit_r = dir_x &&
                 (ball_x + BS <= XR) &&
                 (ball_x + BS + STEP > XR) && ovl_r;

  assign miss_l = !dir_x && (ball_x < STEP);
  assign miss_r = dir_x &&
                  (ball_x + BS + STEP > H_MAX);

  assign inc_l = score_l + 1'b1;
  assign inc_r = score_r + 1'b1;

  always_comb begin
    state_d   = state_q;
    ball_x_d  = ball_x;
    ball_y_d  = ball_y;
    pad_l_d   = pad_l;
    pad_r_d   = pad_r;
    dir_x_d   = dir_x;
    dir_y_d   = dir_y;
    score_l_d = score_l;
    score_r_d = score_r;
    cnt_d     = cnt;
    if (Tick) begin
      if (state_q != GAME_OVER) begin
        pad_l_d = pad_next(pad_l, LeftUp, LeftDown);
        pad_r_d = pad_next(pad_r, RightUp, RightDown);
      end
      case (state_q)
        IDLE: begin
          ball_x_d = BX0;
          ball_y_d = BY0;
          if (Serve) begin
            state_d = SERVE_WAIT;
            cnt_d   = '0;
          end
        end
        SERVE_WAIT: begin
          ball_x_d = BX0;
          ball_y_d = BY0;
          if (cnt == CNT_LAST)
            state_d = PLAY;
          else
            cnt_d = cnt + 1'b1;
        end
        PLAY: begin
          if (!dir_y && ball_y < STEP) begin
            ball_y_d = '0;
            dir_y_d  = 1'b1;
          end else if (dir_y &&
                       ball_y + BS + STEP > V_MAX) begin
            ball_y_d = BY_MAX;
            dir_y_d  = 1'b0;
          end else if (dir_y) begin
            ball_y_d = ball_y + STEP;
          end else begin
            ball_y_d = ball_y - STEP;
          end
          if (hit_l) begin
            ball_x_d = XL_IN;
            dir_x_d  = 1'b1;
          end else if (hit_r) begin
            ball_x_d = XR_IN;
            dir_x_d  = 1'b0;
          end else if (miss_l) begin
            score_r_d = inc_r;
            ball_x_d  = BX0;
            ball_y_d  = BY0;
            dir_x_d   = 1'b0;
            cnt_d     = '0;
            state_d   = (inc_r == WIN) ?
                        GAME_OVER : SERVE_WAIT;
          end else if (miss_r) begin
            score_l_d = inc_l;
            ball_x_d  = BX0;
            ball_y_d  = BY0;
            dir_x_d   = 1'b1;
            cnt_d     = '0;
            state_d   = (inc_l == WIN) ?
                        GAME_OVER : SERVE_WAIT;
          end else if (dir_x) begin
            ball_x_d = ball_x + STEP;
          end else begin
            ball_x_d = ball_x - STEP;
          end
        end
        GAME_OVER: begin
          ball_x_d = BX0;
          ball_y_d = BY0;
          if (Serve) begin
            score_l_d = '0;
            score_r_d = '0;
            pad_l_d   = PY0;
            pad_r_d   = PY0;
            dir_x_d   = 1'b1;
            cnt_d     = '0;
            state_d   = SERVE_WAIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      ball_x  <= BX0;
      ball_y  <= BY0;
      pad_l   <= PY0;
      pad_r   <= PY0;
      dir_x   <= 1'b1;
      dir_y   <= 1'b1;
      score_l <= '0;
      score_r <= '0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      ball_x  <= ball_x_d;
      ball_y  <= ball_y_d;
      pad_l   <= pad_l_d;
      pad_r   <= pad_r_d;
      dir_x   <= dir_x_d;
      dir_y   <= dir_y_d;
      score_l <= score_l_d;
      score_r <= score_r_d;
      cnt     <= cnt_d;
    end
  end

  assign in_ball = (xPos >= ball_x) &&
                   (xPos < ball_x + BS) &&
                   (yPos >= ball_y) &&
                   (yPos < ball_y + BS);
  assign in_pad_l = (xPos >= XL) &&
                    (xPos < XL + PW) &&
                    (yPos >= pad_l) &&
                    (yPos < pad_l + PH);
  assign in_pad_r = (xPos >= XR) &&
                    (xPos < XR + PW) &&
                    (yPos >= pad_r) &&
                    (yPos < pad_r + PH);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      drawBall <= 1'b0;
      drawPadL <= 1'b0;
      drawPadR <= 1'b0;
    end else begin
      drawBall <= in_ball;
      drawPadL <= in_pad_l;
      drawPadR <= in_pad_r;
    end
  end

  assign scoreL   = score_l;
  assign scoreR   = score_r;
  assign state    = state_q;
  assign gameOver = (state_q == GAME_OVER);

endmodule
